// File: rtl/out_queue_pkg.sv
// Shared types for the out_queue block: result-bus format, ROB tag width,
// the output queue entry layout and the tag comparison helper.
package out_queue_pkg;

  localparam int ROB_WIDTH      = 4;
  localparam int CDB_DATA_W     = 32;
  localparam int OUT_DATA_W_MAX = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_t;

  // Entry data is sized for the widest lane; a queue instance uses the low DATA_W bits.
  typedef struct packed {
    logic                      valid;
    logic [ROB_WIDTH-1:0]      tag;
    logic [OUT_DATA_W_MAX-1:0] data;
  } out_entry_t;

  function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] tag);
    return bus.valid && (bus.tag == tag);
  endfunction

endpackage

// File: rtl/out_queue.sv
// In-order output byte queue: entries wait for their operand from the result
// buses and drain to the transmitter as the ROB commits them.
module out_queue
  import out_queue_pkg::*;
#(
  parameter int N_ENTRY = 8,
  parameter int DATA_W  = 8,
  parameter int N_CDB   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  cdb_t                         cdb [N_CDB],
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [ROB_WIDTH-1:0]         issue_tag,
  input  logic                         issue_data_valid,
  input  logic [31:0]                  issue_data,
  input  logic                         commit_valid,
  output logic                         commit_ready,
  input  logic                         flush,
  output logic                         sender_valid,
  input  logic                         sender_ready,
  output logic [DATA_W-1:0]            sender_data,
  output logic [$clog2(N_ENTRY):0]     count
);

  localparam int PTR_W = $clog2(N_ENTRY);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [N_ENTRY-1:0]   r_valid;
  logic [ROB_WIDTH-1:0] r_tag  [N_ENTRY];
  logic [DATA_W-1:0]    r_data [N_ENTRY];

  logic                 w_commit;
  logic                 w_issue;
  out_entry_t           w_new;
  logic [N_ENTRY-1:0]   w_snoop_hit;
  logic [DATA_W-1:0]    w_snoop_data [N_ENTRY];
  logic [N_ENTRY-1:0]   w_valid_next;
  logic [PTR_W-1:0]     w_offset;
  logic                 w_unused_bits;

  assign commit_ready = sender_ready && r_valid[r_head] && (r_count != '0);
  assign w_commit     = commit_valid && commit_ready && !flush;
  assign sender_valid = w_commit;
  assign sender_data  = r_data[r_head];
  assign issue_ready  = !flush && ((r_count < CNT_W'(N_ENTRY)) || w_commit);
  assign w_issue      = issue_valid && issue_ready;
  assign count        = r_count;

  // Incoming entry: the operand supplied with the issue beats any bus,
  // and among buses the lowest index wins (scan runs high to low).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_new     = '0;
    w_new.tag = issue_tag;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (tag_match(cdb[k], issue_tag)) begin
        w_new.valid             = 1'b1;
        w_new.data[DATA_W-1:0]  = cdb[k].data[DATA_W-1:0];
      end
    end
    if (issue_data_valid) begin
      w_new.valid            = 1'b1;
      w_new.data[DATA_W-1:0] = issue_data[DATA_W-1:0];
    end
  end

  // Occupied, still-waiting entries snoop the result buses every cycle.
  always_comb begin
    w_offset = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      w_offset        = PTR_W'(i) - r_head;
      w_snoop_hit[i]  = 1'b0;
      w_snoop_data[i] = '0;
      for (int k = N_CDB - 1; k >= 0; k--) begin
        if (tag_match(cdb[k], r_tag[i])) begin
          w_snoop_hit[i]  = ({1'b0, w_offset} < r_count) && !r_valid[i];
          w_snoop_data[i] = cdb[k].data[DATA_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_valid_next = r_valid | w_snoop_hit;
    if (w_commit) w_valid_next[r_head] = 1'b0;
    if (w_issue)  w_valid_next[r_tail] = w_new.valid;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_commit);
      r_tail  <= r_tail + PTR_W'(w_issue);
      r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_commit);
      r_valid <= w_valid_next;
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRY; i++) begin
      if (w_snoop_hit[i]) r_data[i] <= w_snoop_data[i];
    end
    if (w_issue) begin
      r_tag[r_tail]  <= w_new.tag;
      r_data[r_tail] <= w_new.data[DATA_W-1:0];
    end
  end

  // Upper bus/operand bits beyond the lane width are intentionally ignored.
  always_comb begin
    w_unused_bits = ^w_new.data ^ ^issue_data;
    for (int k = 0; k < N_CDB; k++) w_unused_bits = w_unused_bits ^ ^cdb[k].data;
  end

endmodule

// File: doc/out_queue.md
OUT_QUEUE -- requirements
Module: out_queue

Interface
REQ-001 SHALL have parameter N_ENTRY, default 8, queue depth, power of two and at least 2.
REQ-002 SHALL have parameter DATA_W, default 8, output byte-lane width, 1..32.
REQ-003 SHALL have parameter N_CDB, default 2, number of result buses snooped.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cdb, input, cdb_t[N_CDB], result buses (valid, ROB tag, 32-bit data).
REQ-007 SHALL have port issue_valid, input, 1, and port issue_ready, output, 1, issue handshake.
REQ-008 SHALL have port issue_tag, input, ROB_WIDTH, producer tag of the source operand.
REQ-009 SHALL have port issue_data_valid, input, 1, and port issue_data, input, 32, operand when already available.
REQ-010 SHALL have port commit_valid, input, 1, and port commit_ready, output, 1, in-order commit handshake from ROB.
REQ-011 SHALL have port flush, input, 1, synchronous discard of all entries (mispredict).
REQ-012 SHALL have port sender_valid, output, 1, port sender_ready, input, 1, and port sender_data, output, DATA_W, transmitter interface.
REQ-013 SHALL have port count, output, $clog2(N_ENTRY)+1, current occupancy.

Function
REQ-014 SHALL store entries in a circular buffer with head and tail pointers of $clog2(N_ENTRY) bits wrapping modulo N_ENTRY; no entry shifting.
REQ-015 SHALL assert issue_ready when count < N_ENTRY or a commit fires in the same cycle, and never while flush is high.
REQ-016 SHALL write one entry at tail on issue_valid && issue_ready: data valid if issue_data_valid or any CDB matches issue_tag this cycle; data taken from issue_data first, else from the lowest-index matching CDB.
REQ-017 SHALL, every cycle, set each occupied, not-yet-valid entry valid and capture cdb[k].data[DATA_W-1:0] from the lowest-index bus k whose valid is high and whose tag matches; valid entries SHALL be left unchanged.
REQ-018 SHALL drive commit_ready = sender_ready && head entry valid && count != 0, and sender_valid = commit_valid && commit_ready.
REQ-019 SHALL drive sender_data from the head entry data combinationally (zero latency from head valid to sender).
REQ-020 SHALL pop the head on commit_valid && commit_ready; byte is consumed by the sender in that same cycle.
REQ-021 SHALL update count by +issue -commit each cycle; simultaneous issue and commit at count N_ENTRY SHALL leave count at N_ENTRY, and at count 1 SHALL leave it at 1.
REQ-022 SHALL ignore commit_valid while count == 0 (commit_ready low) and raise no state change.
REQ-023 SHALL, on flush, set count, head and tail to 0 and clear all entry valid bits next cycle; flush overrides issue and commit in the same cycle, and sender_valid SHALL be low during flush.
REQ-024 SHALL hold data and tag of unoccupied entries as don't-care; only valid bits and pointers are architecturally visible.

Reset
REQ-025 SHALL, while reset_n is low, asynchronously force count, head, tail and all entry valid bits to 0, so that issue_ready=1, commit_ready=0, sender_valid=0.
REQ-026 SHALL accept an issue on the first rising clk edge after reset_n deasserts.

Structure
REQ-027 SHALL take cdb_t, ROB_WIDTH and a tag_match function from the shared common package; the out_entry struct (valid, tag, data) SHALL be declared there, parametrised by DATA_W.
REQ-028 SHALL be a single module; no sub-module required.

Verification
REQ-029 Reset then issue tag 3 with data 0x41 valid, sender_ready=1, commit_valid -> sender_data=0x41, sender_valid=1 in commit cycle, count 1->0.
REQ-030 Issue tag 5 not ready; cdb[1]={1,5,0x1234_5642} two cycles later; commit -> sender_data=0x42; commit_ready low until the cycle after capture.
REQ-031 Issue tag 7 not ready while cdb[0] carries tag 7 data 0x55 in the same cycle -> entry valid immediately, next-cycle commit outputs 0x55.
REQ-032 Fill 8 entries (0x00..0x07), then issue 0x08 while committing -> issue_ready=1, count stays 8, output order 0x00..0x08 across pointer wrap.
REQ-033 Four entries queued, flush together with issue_valid and commit_valid -> no sender_valid, count=0 next cycle, next issued 0x99 is the next byte sent.
REQ-034 Head not ready, commit_valid=1, sender_ready=1 -> commit_ready=0 and sender_valid=0 until CDB delivers tag; reset_n pulsed low mid-queue -> count=0 immediately, before any clk edge.
